seq_div: RTL and testbench

- Iterative restoring unsigned divider; the inverse operation of the team's shift-add multiplier.
- Computes one quotient bit per clock, with a start/done handshake.
- Sits beside the multiplier in the combination/arithmetic IP library.
- Intended for datapaths where area matters more than latency.

---
 rtl/seq_div.sv | 100 ++++++++++
 tb/tb_seq_div.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/seq_div.sv
// Iterative restoring unsigned divider: one quotient bit per clock behind a
// start/done handshake. Results are held until the next accepted request completes.
module seq_div #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] dvd_shift;   // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] part_rem;
  logic [CW-1:0]    count;
  logic             dz_q;
  logic [WIDTH:0]   rem_shifted;
  logic [WIDTH:0]   trial;

  assign rem_shifted = {part_rem, dvd_shift[WIDTH-1]};
  assign trial       = rem_shifted - {1'b0, dvs_q};
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FIN is left once count is nonzero. A normal division arrives with
  // count==WIDTH; a divide-by-zero arrives with count==0 and waits one cycle,
  // giving it a fixed two-clock latency.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (divisor == '0) ? FIN : CALC;
      CALC:    if (count == CW'(WIDTH - 1)) state_next = FIN;
      FIN:     if (count != '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_shift   <= '0;
      dvs_q       <= '0;
      part_rem    <= '0;
      count       <= '0;
      dz_q        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd_shift <= dividend;
            dvs_q     <= divisor;
            part_rem  <= '0;
            count     <= '0;
            dz_q      <= (divisor == '0);
          end
        end
        CALC: begin
          // A borrow in the top bit means the trial went negative: restore.
          part_rem  <= trial[WIDTH] ? rem_shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          dvd_shift <= {dvd_shift[WIDTH-2:0], ~trial[WIDTH]};
          count     <= count + CW'(1);
        end
        FIN: begin
          if (count != '0) begin
            quotient    <= dz_q ? '1 : dvd_shift;
            remainder   <= dz_q ? dvd_shift : part_rem;
            div_by_zero <= dz_q;
            done        <= 1'b1;
          end else begin
            count <= count + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div (WIDTH=8): directed scenarios plus a
// randomized sweep against a plain-arithmetic reference model.
module tb_seq_div;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int total = 0;
  int bad   = 0;

  seq_div #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: integer division; divisor 0 yields all ones, remainder = dividend.
  function automatic void model(input int a, input int b, output int q, output int r,
                                output bit dz, output int lat);
    if (b == 0) begin
      q = (1 << W) - 1; r = a; dz = 1'b1; lat = 2;
    end else begin
      q = a / b; r = a % b; dz = 1'b0; lat = W + 1;
    end
  endfunction

  // Caller is between edges; request is accepted on the next rising edge.
  task automatic launch(input int a, input int b);
    start = 1'b1; dividend = W'(a); divisor = W'(b);
    @(posedge clk); #1;
    start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
  endtask

  // Counts edges until done is seen (#1 after each edge); bounded at 40.
  task automatic wait_done(output int lat, output bit busy_ok);
    lat = 0; busy_ok = busy;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    #2;
    total++;
    if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
      bad++;
      $display("FAIL reset_state: got busy=%b done=%b dz=%b q=%0d r=%0d, want all zero",
               busy, done, div_by_zero, quotient, remainder);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat; bit bok;
    launch(200, 7);
    wait_done(lat, bok);
    total++; if (lat !== 9) begin bad++; $display("FAIL basic_latency: got %0d want 9", lat); end
    total++; if (bok !== 1'b1) begin bad++; $display("FAIL basic_busy_span: busy dropped before done"); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done: got %b want 0", busy); end
    total++; if (quotient !== 8'd28) begin bad++; $display("FAIL basic_q: got %0d want 28", quotient); end
    total++; if (remainder !== 8'd4) begin bad++; $display("FAIL basic_r: got %0d want 4", remainder); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL basic_dz: got %b want 0", div_by_zero); end
    @(posedge clk); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse: got %b want 0", done); end
    total++; if (quotient !== 8'd28) begin bad++; $display("FAIL basic_q_hold: got %0d want 28", quotient); end
  endtask

  task automatic run_one(input string name, input int a, input int b);
    int lat, eq, er, elat; bit bok, edz;
    model(a, b, eq, er, edz, elat);
    launch(a, b);
    wait_done(lat, bok);
    total++; if (lat !== elat) begin bad++; $display("FAIL %s_latency: got %0d want %0d", name, lat, elat); end
    total++; if (quotient !== W'(eq)) begin bad++; $display("FAIL %s_q: got %0d want %0d", name, quotient, eq); end
    total++; if (remainder !== W'(er)) begin bad++; $display("FAIL %s_r: got %0d want %0d", name, remainder, er); end
    total++; if (div_by_zero !== edz) begin bad++; $display("FAIL %s_dz: got %b want %b", name, div_by_zero, edz); end
  endtask

  task automatic test_corners;
    int tab [3][2] = '{'{255, 1}, '{5, 9}, '{0, 3}};
    for (int i = 0; i < 3; i++) run_one($sformatf("corner%0d", i), tab[i][0], tab[i][1]);
  endtask

  task automatic test_div_zero;
    run_one("dz", 100, 0);
    run_one("after_dz", 9, 3);
  endtask

  task automatic test_busy_ignore;
    int lat, dones; bit bok;
    launch(200, 7);
    @(posedge clk); @(posedge clk); #1;
    start = 1'b1; dividend = 8'd50; divisor = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bok);
    total++; if (lat !== 6) begin bad++; $display("FAIL ignore_latency: got %0d want 6", lat); end
    total++; if (quotient !== 8'd28) begin bad++; $display("FAIL ignore_q: got %0d want 28", quotient); end
    total++; if (remainder !== 8'd4) begin bad++; $display("FAIL ignore_r: got %0d want 4", remainder); end
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    total++; if (dones !== 0) begin bad++; $display("FAIL ignore_extra_done: got %0d want 0", dones); end
  endtask

  task automatic test_back_to_back;
    run_one("b2b_first", 20, 3);
    run_one("b2b_second", 99, 10);
  endtask

  task automatic test_reset_abort;
    int dones, busies;
    launch(200, 7);
    repeat (4) @(posedge clk);
    #2; rst_n = 1'b0; #1;
    total++;
    if ({busy, done, quotient} !== '0) begin
      bad++;
      $display("FAIL abort_clear: got busy=%b done=%b q=%0d, want 0 0 0", busy, done, quotient);
    end
    @(negedge clk); rst_n = 1'b1;
    dones = 0; busies = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
      if (busy) busies++;
    end
    total++; if (dones !== 0) begin bad++; $display("FAIL abort_no_done: got %0d want 0", dones); end
    total++; if (busies !== 0) begin bad++; $display("FAIL abort_idle: busy cycles %0d want 0", busies); end
    run_one("after_abort", 81, 9);
  endtask

  task automatic test_random;
    int a, b;
    for (int n = 0; n < 2000; n++) begin
      a = int'($urandom_range(0, 255));
      b = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 255));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
      run_one("rand", a, b);
      if (b != 0) begin
        total++;
        if ((int'(quotient) * b + int'(remainder) != a) || (int'(remainder) >= b)) begin
          bad++;
          $display("FAIL rand_identity: %0d/%0d got q=%0d r=%0d", a, b, quotient, remainder);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_corners;
    test_div_zero;
    test_busy_ignore;
    test_back_to_back;
    test_reset_abort;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
